// File: rtl/bla_line_arbiter.sv
// Round-robin arbiter sharing one Bresenham line engine between NUM_REQ requesters.
// Optional draw watchdog enabled by defining BLA_ARB_TIMEOUT_EN.
module bla_line_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int GID_W          = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*32-1:0]  seg_in,
    input  logic                   draw_done,
    output logic [7:0]             x0,
    output logic [7:0]             y0,
    output logic [7:0]             x1,
    output logic [7:0]             y1,
    output logic                   draw_en,
    output logic [NUM_REQ-1:0]     ack,
    output logic [GID_W-1:0]       grant_id,
    output logic                   busy,
    output logic                   timeout_err,
    output logic [1:0]             state_dbg
);

    typedef enum logic [1:0] {IDLE, DRAW, ACK, GAP} state_t;

    state_t           state, state_nxt;
    logic [GID_W-1:0] last_grant;
    logic [31:0]      seg_reg;
    logic             win_valid;
    logic [GID_W-1:0] win_id;
    logic [GID_W-1:0] cand;
    logic [31:0]      win_seg;
    logic             to_hit;

    // Handshake: req is a level held until its one-cycle ack; the engine sees
    // draw_en high for the whole DRAW state and answers with a draw_done strobe.

    // Scan downward so the candidate nearest last_grant+1 is written last and wins.
    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = GID_W'((int'(last_grant) + k) % NUM_REQ);
            if (req[cand]) begin
                win_valid = 1'b1;
                win_id    = cand;
            end
        end
    end

    always_comb begin
        win_seg = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (GID_W'(i) == win_id) win_seg = seg_in[i*32 +: 32];
        end
    end

`ifdef BLA_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] to_cnt;

    assign to_hit = (state == DRAW) && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counter is held at zero outside DRAW, so it restarts on every DRAW entry.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            to_cnt      <= (state == DRAW) ? to_cnt + 1'b1 : '0;
            timeout_err <= to_hit && !draw_done;
        end
    end
`else
    assign to_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_valid) state_nxt = DRAW;
            DRAW:    if (draw_done || to_hit) state_nxt = ACK;
            ACK:     state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            grant_id   <= '0;
            seg_reg    <= '0;
            last_grant <= GID_W'(NUM_REQ - 1);
        end else begin
            if (state == IDLE && win_valid) begin
                grant_id <= win_id;
                seg_reg  <= win_seg;
            end
            if (state == ACK) last_grant <= grant_id;
        end
    end

    always_comb begin
        draw_en = (state == DRAW);
        busy    = (state != IDLE);
        ack     = (state == ACK) ? (NUM_REQ'(1) << grant_id) : '0;
        {y1, x1, y0, x0} = (state == DRAW) ? seg_reg : 32'd0;
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_bla_line_arbiter.sv
// Directed bench for bla_line_arbiter: stimulus pushes expected acks, a monitor pops them.
module tb_bla_line_arbiter;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           n_rst = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*32-1:0] seg_in = '0;
    logic           draw_done = 1'b0;
    logic [7:0]     x0, y0, x1, y1;
    logic           draw_en, busy, timeout_err;
    logic [N-1:0]   ack;
    logic [1:0]     grant_id;
    logic [1:0]     state_dbg;

    int checks = 0;
    int errors = 0;
    logic [36:0] exp_q[$];
    logic [31:0] cap = '0;

    bla_line_arbiter #(.NUM_REQ(N), .GID_W(2), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .n_rst(n_rst), .req(req), .seg_in(seg_in), .draw_done(draw_done),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .draw_en(draw_en), .ack(ack),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, want);
        end
    endtask

    function automatic logic [31:0] mk(input logic [7:0] ax0, ay0, ax1, ay1);
        return {ay1, ax1, ay0, ax0};
    endfunction

    function automatic logic [36:0] item(input logic [N-1:0] a, input logic [31:0] s, input logic t);
        return {a, s, t};
    endfunction

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_draw_en;
        for (int i = 0; i < 20; i++) begin
            if (draw_en) break;
            cyc();
        end
        chk("draw_en_wait", draw_en, 1);
    endtask

    task automatic run_draw(input int n, input int gid);
        wait_draw_en();
        chk("grant_id", grant_id, gid);
        repeat (n - 1) cyc();
        draw_done = 1'b1;
        cyc();
        draw_done = 1'b0;
    endtask

    task automatic apply_reset;
        n_rst = 1'b0;
        req = '0;
        draw_done = 1'b0;
        repeat (2) cyc();
        chk("rst_outputs", {draw_en, ack, busy, timeout_err, grant_id, x0, y0, x1, y1}, 0);
        n_rst = 1'b1;
    endtask

    // Monitor: capture coordinates during DRAW, compare against the queue on each ack.
    always @(negedge clk) begin
        if (n_rst) begin
            if (draw_en) cap = {y1, x1, y0, x0};
            if (ack != '0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack got %b want none", ack);
                end else begin
                    chk("ack_item", {ack, cap, timeout_err}, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog got timeout want finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        // Single requester, five-cycle draw
        apply_reset();
        seg_in[31:0] = mk(8'd0, 8'd0, 8'd10, 8'd20);
        req = 4'b0001;
        exp_q.push_back(item(4'b0001, mk(8'd0, 8'd0, 8'd10, 8'd20), 1'b0));
        cyc();
        chk("t1_draw_en", draw_en, 1);
        chk("t1_coords", {x0, y0, x1, y1}, {8'd0, 8'd0, 8'd10, 8'd20});
        repeat (4) cyc();
        draw_done = 1'b1;
        cyc();
        draw_done = 1'b0;
        chk("t1_ack_state", {busy, draw_en, ack, x1, y1}, {1'b1, 1'b0, 4'b0001, 16'd0});
        req = '0;
        cyc();
        chk("t1_gap", {busy, ack}, {1'b1, 4'b0000});
        cyc();
        chk("t1_idle", busy, 0);

        // All requesters held: round robin 0,1,2,3,0
        apply_reset();
        for (int i = 0; i < N; i++) seg_in[i*32 +: 32] = mk(8'(10*i), 8'(10*i+1), 8'(10*i+2), 8'(10*i+3));
        req = 4'b1111;
        for (int k = 0; k < 5; k++)
            exp_q.push_back(item(4'b0001 << (k % 4), mk(8'(10*(k%4)), 8'(10*(k%4)+1), 8'(10*(k%4)+2), 8'(10*(k%4)+3)), 1'b0));
        for (int k = 0; k < 5; k++) begin
            run_draw(2, k % 4);
            if (k == 4) req = '0;
        end
        repeat (2) cyc();

        // Segment change and req drop mid-DRAW are ignored
        seg_in[64 +: 32] = mk(8'd50, 8'd60, 8'd70, 8'd80);
        req = 4'b0100;
        exp_q.push_back(item(4'b0100, mk(8'd50, 8'd60, 8'd70, 8'd80), 1'b0));
        wait_draw_en();
        chk("t3_grant", grant_id, 2);
        seg_in[64 +: 32] = mk(8'd1, 8'd1, 8'd1, 8'd1);
        req = '0;
        cyc();
        chk("t3_coords_hold", {y1, x1, y0, x0}, mk(8'd50, 8'd60, 8'd70, 8'd80));
        chk("t3_still_draw", draw_en, 1);
        draw_done = 1'b1;
        cyc();
        draw_done = 1'b0;
        repeat (2) cyc();

        // Reset during a draw of requester 1, then requester 0 first
        seg_in[31:0]  = mk(8'd1, 8'd2, 8'd3, 8'd4);
        seg_in[63:32] = mk(8'd5, 8'd6, 8'd7, 8'd8);
        req = 4'b0010;
        wait_draw_en();
        chk("t4_grant", grant_id, 1);
        cyc();
        #2;
        n_rst = 1'b0;
        #1;
        chk("t4_async_rst", {draw_en, ack, busy, x0, y0, x1, y1}, 0);
        req = 4'b0011;
        exp_q.push_back(item(4'b0001, mk(8'd1, 8'd2, 8'd3, 8'd4), 1'b0));
        exp_q.push_back(item(4'b0010, mk(8'd5, 8'd6, 8'd7, 8'd8), 1'b0));
        cyc();
        n_rst = 1'b1;
        run_draw(2, 0);
        req = 4'b0010;
        run_draw(2, 1);
        req = '0;
        repeat (2) cyc();

        // draw_done in IDLE and in GAP is ignored
        draw_done = 1'b1;
        cyc();
        draw_done = 1'b0;
        chk("t5_idle_done", {busy, ack}, 0);
        seg_in[96 +: 32] = mk(8'd9, 8'd8, 8'd7, 8'd6);
        req = 4'b1000;
        exp_q.push_back(item(4'b1000, mk(8'd9, 8'd8, 8'd7, 8'd6), 1'b0));
        run_draw(1, 3);
        req = '0;
        cyc();
        chk("t5_in_gap", {busy, draw_en, ack}, {1'b1, 1'b0, 4'b0000});
        draw_done = 1'b1;
        cyc();
        draw_done = 1'b0;
        chk("t5_gap_done", {busy, ack}, 0);
        cyc();
        chk("t5_stay_idle", {busy, draw_en}, 0);

`ifdef BLA_ARB_TIMEOUT_EN
        // Watchdog abort after 8 DRAW cycles, then draw_done on the terminal cycle
        seg_in[31:0] = mk(8'd11, 8'd12, 8'd13, 8'd14);
        req = 4'b0001;
        exp_q.push_back(item(4'b0001, mk(8'd11, 8'd12, 8'd13, 8'd14), 1'b1));
        wait_draw_en();
        repeat (8) cyc();
        chk("to_ack", {ack, timeout_err}, {4'b0001, 1'b1});
        exp_q.push_back(item(4'b0001, mk(8'd11, 8'd12, 8'd13, 8'd14), 1'b0));
        wait_draw_en();
        repeat (7) cyc();
        draw_done = 1'b1;
        cyc();
        draw_done = 1'b0;
        chk("to_coincide", {ack, timeout_err}, {4'b0001, 1'b0});
        req = '0;
        repeat (2) cyc();
`endif

        repeat (3) cyc();
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
